// File: rtl/mult_frac_pkg.sv
// Shared types and sizing helpers for the sequential fraction multiplier.
package mult_frac_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Ceiling log2, never less than 1 so a counter always has at least one bit
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < n) begin
                r = i + 1;
            end
        end
        return (r == 0) ? 1 : r;
    endfunction

    function automatic int unsigned num_iter(input int unsigned width, input int unsigned bpc);
        return width / bpc;
    endfunction

    function automatic int unsigned acc_width(input int unsigned width, input int unsigned bpc);
        return 2 * width + bpc;
    endfunction

endpackage

// File: rtl/mult_frac_step.sv
// One radix-2^BPC iteration: add digit*a into the accumulator's upper half, then shift right by BPC.
module mult_frac_step
    import mult_frac_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned BPC   = 2,
    parameter int unsigned ACCW  = 2 * WIDTH + BPC
) (
    input  logic [ACCW-1:0]  acc_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [BPC-1:0]   digit_i,
    output logic [ACCW-1:0]  acc_o
);

    logic [WIDTH+BPC-1:0] pp;
    logic [ACCW-1:0]      sum;

    // The extra BPC accumulator bits absorb the carry, so the add never loses precision
    always_comb begin
        pp = '0;
        for (int unsigned i = 0; i < BPC; i++) begin
            if (digit_i[i]) begin
                pp = pp + ((WIDTH + BPC)'(a_i) << i);
            end
        end
        sum   = acc_i + {pp, {WIDTH{1'b0}}};
        acc_o = sum >> BPC;
    end

endmodule

// File: rtl/mult_frac_seq.sv
// Iterative unsigned fraction multiplier (upper half + sticky, exact product alongside).
// Define MULT_FRAC_RNE_EN to round prod to nearest-even instead of truncating.
module mult_frac_seq
    import mult_frac_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned BPC   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     prod,
    output logic [2*WIDTH-1:0]   prod_full,
    output logic                 sticky
);

    localparam int unsigned N    = num_iter(WIDTH, BPC);
    localparam int unsigned CW   = clog2(N);
    localparam int unsigned ACCW = acc_width(WIDTH, BPC);

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     bsh_q, bsh_d;
    logic [ACCW-1:0]      acc_q, acc_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     prod_q, prod_d;
    logic [2*WIDTH-1:0]   full_q, full_d;
    logic                 sticky_q, sticky_d;
    logic                 done_q, done_d;

    logic                 load, iter, last;
    logic [ACCW-1:0]      step_acc;
`ifdef MULT_FRAC_RNE_EN
    logic                 guard, rest;
`endif

    mult_frac_step #(
        .WIDTH (WIDTH),
        .BPC   (BPC),
        .ACCW  (ACCW)
    ) u_step (
        .acc_i   (acc_q),
        .a_i     (a_q),
        .digit_i (bsh_q[BPC-1:0]),
        .acc_o   (step_acc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            bsh_q    <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            prod_q   <= '0;
            full_q   <= '0;
            sticky_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            bsh_q    <= bsh_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            prod_q   <= prod_d;
            full_q   <= full_d;
            sticky_q <= sticky_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start) state_d = RUN;
            RUN:  if (last)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == RUN);
        load = (state_q == IDLE) && start;
        iter = (state_q == RUN);
        last = iter && (cnt_q == CW'(N - 1));
        done      = done_q;
        prod      = prod_q;
        prod_full = full_q;
        sticky    = sticky_q;
    end

    always_comb begin
        a_d      = a_q;
        bsh_d    = bsh_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        prod_d   = prod_q;
        full_d   = full_q;
        sticky_d = sticky_q;
        done_d   = 1'b0;
`ifdef MULT_FRAC_RNE_EN
        guard    = 1'b0;
        rest     = 1'b0;
`endif
        if (load) begin
            a_d   = a;
            bsh_d = b;
            acc_d = '0;
            cnt_d = '0;
        end
        if (iter) begin
            acc_d = step_acc;
            bsh_d = bsh_q >> BPC;
            cnt_d = cnt_q + CW'(1);
        end
        // After N steps the top BPC accumulator bits are always zero
        if (last) begin
            full_d   = step_acc[2*WIDTH-1:0];
            sticky_d = |full_d[WIDTH-1:0];
`ifdef MULT_FRAC_RNE_EN
            guard    = full_d[WIDTH-1];
            rest     = |full_d[WIDTH-2:0];
            prod_d   = full_d[2*WIDTH-1:WIDTH] + WIDTH'(guard & (rest | full_d[WIDTH]));
`else
            prod_d   = full_d[2*WIDTH-1:WIDTH];
`endif
            done_d   = 1'b1;
        end
    end

endmodule

// File: tb/tb_mult_frac_seq.sv
// Directed self-checking bench for mult_frac_seq (WIDTH=8, BPC=2); honours MULT_FRAC_RNE_EN.
module tb_mult_frac_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        busy;
    logic        done;
    logic [7:0]  prod;
    logic [15:0] prod_full;
    logic        sticky;

    int checks = 0;
    int errors = 0;

    mult_frac_seq #(
        .WIDTH (8),
        .BPC   (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .prod      (prod),
        .prod_full (prod_full),
        .sticky    (sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Start an op and wait (bounded) for done; lat = edges after the start-sampling edge
    task automatic do_op(input logic [7:0] av, input logic [7:0] bv, output int lat);
        @(negedge clk);
        a = av;
        b = bv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    typedef struct {
        logic [7:0]  av;
        logic [7:0]  bv;
        logic [15:0] full;
        logic [7:0]  p_trunc;
        logic [7:0]  p_rne;
        logic        stk;
    } vec_t;

    vec_t vecs[$];
    int   lat;

    initial begin
        vecs.push_back('{8'h80, 8'h80, 16'h4000, 8'h40, 8'h40, 1'b0});
        vecs.push_back('{8'hFF, 8'hFF, 16'hFE01, 8'hFE, 8'hFE, 1'b1});
        vecs.push_back('{8'h80, 8'h03, 16'h0180, 8'h01, 8'h02, 1'b1});
        vecs.push_back('{8'h80, 8'h05, 16'h0280, 8'h02, 8'h02, 1'b1});
        vecs.push_back('{8'hAB, 8'hCD, 16'h88EF, 8'h88, 8'h89, 1'b1});
        vecs.push_back('{8'hC0, 8'hC0, 16'h9000, 8'h90, 8'h90, 1'b0});
        vecs.push_back('{8'hFF, 8'h01, 16'h00FF, 8'h00, 8'h01, 1'b1});
        vecs.push_back('{8'h01, 8'h01, 16'h0001, 8'h00, 8'h00, 1'b1});
        vecs.push_back('{8'h00, 8'h5A, 16'h0000, 8'h00, 8'h00, 1'b0});

        rst = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_prod", 32'(prod), 32'd0);
        check("reset_full", 32'(prod_full), 32'd0);
        check("reset_sticky", 32'(sticky), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) begin
            do_op(vecs[i].av, vecs[i].bv, lat);
            check($sformatf("lat_%0d", i), 32'(lat), 32'd4);
            check($sformatf("full_%0d", i), 32'(prod_full), 32'(vecs[i].full));
`ifdef MULT_FRAC_RNE_EN
            check($sformatf("prod_%0d", i), 32'(prod), 32'(vecs[i].p_rne));
`else
            check($sformatf("prod_%0d", i), 32'(prod), 32'(vecs[i].p_trunc));
`endif
            check($sformatf("sticky_%0d", i), 32'(sticky), 32'(vecs[i].stk));
            check($sformatf("busy_done_%0d", i), 32'(busy), 32'd0);
            @(posedge clk);
            #1;
            check($sformatf("done_pulse_%0d", i), 32'(done), 32'd0);
            check($sformatf("hold_%0d", i), 32'(prod_full), 32'(vecs[i].full));
        end

        // Start while busy is ignored; start in the done cycle is accepted
        @(negedge clk);
        a = 8'h00;
        b = 8'hAB;
        start = 1'b1;
        @(posedge clk);
        #1;
        check("ign_busy", 32'(busy), 32'd1);
        for (int i = 1; i <= 3; i++) begin
            a = 8'hFF;
            start = 1'b1;
            @(posedge clk);
            #1;
            check($sformatf("ign_nodone_%0d", i), 32'(done), 32'd0);
        end
        start = 1'b0;
        @(posedge clk);
        #1;
        check("ign_done", 32'(done), 32'd1);
        check("ign_prod", 32'(prod), 32'd0);
        check("ign_full", 32'(prod_full), 32'd0);
        check("ign_sticky", 32'(sticky), 32'd0);
        a = 8'h80;
        b = 8'h80;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b_single_done", 32'(done), 32'd0);
        check("b2b_busy", 32'(busy), 32'd1);
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("b2b_lat", 32'(lat), 32'd4);
        check("b2b_full", 32'(prod_full), 32'h4000);
        check("b2b_prod", 32'(prod), 32'h40);

        // Reset in the middle of RUN aborts without a done pulse
        @(negedge clk);
        a = 8'hFF;
        b = 8'hFF;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_prod", 32'(prod), 32'd0);
        check("abort_full", 32'(prod_full), 32'd0);
        check("abort_sticky", 32'(sticky), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("abort_nodone_%0d", i), 32'(done), 32'd0);
        end
        do_op(8'hAB, 8'hCD, lat);
        check("post_lat", 32'(lat), 32'd4);
        check("post_full", 32'(prod_full), 32'h88EF);
`ifdef MULT_FRAC_RNE_EN
        check("post_prod", 32'(prod), 32'h89);
`else
        check("post_prod", 32'(prod), 32'h88);
`endif
        check("post_sticky", 32'(sticky), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
